// File: rtl/map_access_arbiter_pkg.sv
// Shared types and helpers for the world-map ROM access arbiter.
// Owner encoding is also the tag carried down the read pipeline.
package map_arb_pkg;

    localparam int MAP_ADDR_W = 14;
    localparam int MAP_DATA_W = 2;

    typedef enum logic [1:0] {
        OWN_V = 2'd0,
        OWN_B = 2'd1,
        OWN_C = 2'd2
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    // Next value of a B/C wait counter: counts unserved request cycles, saturating at lim.
    function automatic logic [7:0] next_wait(input logic [7:0] cnt, input logic req,
                                             input logic gnt, input logic [7:0] lim);
        if (!req || gnt) return 8'd0;
        if (cnt >= lim) return lim;
        return cnt + 8'd1;
    endfunction

endpackage

// File: rtl/map_access_arbiter_if.sv
// One requester's view of the map read port: request/address out, grant and read data back.
interface map_arb_req_if
    import map_arb_pkg::*;
#(
    parameter int ADDR_W = MAP_ADDR_W,
    parameter int DATA_W = MAP_DATA_W
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/map_access_arbiter_tagpipe.sv
// Owner tag delay line matching the ROM read latency; the last stage lines up with rom_data.
module map_arb_tagpipe
    import map_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  tag_t in_tag,
    output tag_t out_tag
);

    tag_t [RD_LAT-1:0] stages;

    // Reset discards every in-flight tag so no response escapes for reads granted before it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stages <= '0;
        end else begin
            stages[0] <= in_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign out_tag = stages[RD_LAT-1];

endmodule

// File: rtl/map_access_arbiter.sv
// Shares the map ROM read port between video (V), bot simulator (B) and PicoBlaze (C):
// V has priority, B/C round-robin, and a starving B/C pre-empts V.
module map_access_arbiter
    import map_arb_pkg::*;
#(
    parameter int ADDR_W     = MAP_ADDR_W,
    parameter int DATA_W     = MAP_DATA_W,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    map_arb_req_if.slave      v,
    map_arb_req_if.slave      b,
    map_arb_req_if.slave      c,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              starve_evt
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]  wait_b, wait_c;
    logic        rr_c;          // 1: C wins the next B/C tie, 0: B wins
    logic        urg_b, urg_c;
    logic        win_valid, win_urgent;
    owner_t      win_owner;
    tag_t        grant_tag, done_tag;
    logic [2:0]  rsp_valid;
    logic [DATA_W-1:0] rdata_v, rdata_b, rdata_c;

    assign urg_b = b.req && (wait_b == STARVE_LIM);
    assign urg_c = c.req && (wait_c == STARVE_LIM);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        win_valid  = 1'b0;
        win_urgent = 1'b0;
        win_owner  = OWN_V;
        if (reset) begin
            if (urg_b || urg_c) begin
                win_valid  = 1'b1;
                win_urgent = 1'b1;
                if (urg_b && urg_c) win_owner = rr_c ? OWN_C : OWN_B;
                else                win_owner = urg_b ? OWN_B : OWN_C;
            end else if (v.req) begin
                win_valid = 1'b1;
                win_owner = OWN_V;
            end else if (b.req || c.req) begin
                win_valid = 1'b1;
                if (b.req && c.req) win_owner = rr_c ? OWN_C : OWN_B;
                else                win_owner = b.req ? OWN_B : OWN_C;
            end
        end
    end

    assign v.gnt      = win_valid && (win_owner == OWN_V);
    assign b.gnt      = win_valid && (win_owner == OWN_B);
    assign c.gnt      = win_valid && (win_owner == OWN_C);
    assign rom_en     = win_valid;
    assign starve_evt = win_urgent && v.req;

    always_comb begin
        rom_addr = '0;
        if (win_valid) begin
            case (win_owner)
                OWN_V:   rom_addr = v.addr;
                OWN_B:   rom_addr = b.addr;
                OWN_C:   rom_addr = c.addr;
                default: rom_addr = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_b <= '0;
            wait_c <= '0;
            rr_c   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            wait_b <= next_wait(wait_b, b.req, b.gnt, STARVE_LIM);
            wait_c <= next_wait(wait_c, c.req, c.gnt, STARVE_LIM);
            if (b.gnt)      rr_c <= 1'b1;
            else if (c.gnt) rr_c <= 1'b0;
        end
    end

    assign grant_tag = '{valid: win_valid, owner: win_owner};

    map_arb_tagpipe #(
        .RD_LAT (RD_LAT)
    ) u_tagpipe (
        .clk     (clk),
        .reset   (reset),
        .in_tag  (grant_tag),
        .out_tag (done_tag)
    );

    // Only the owner's data register loads; the others keep their last response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= '0;
            rdata_v   <= '0;
            rdata_b   <= '0;
            rdata_c   <= '0;
        end else begin
            rsp_valid <= '0;
            if (done_tag.valid) begin
                case (done_tag.owner)
                    OWN_V: begin
                        rsp_valid <= 3'b001;
                        rdata_v   <= rom_data;
                    end
                    OWN_B: begin
                        rsp_valid <= 3'b010;
                        rdata_b   <= rom_data;
                    end
                    OWN_C: begin
                        rsp_valid <= 3'b100;
                        rdata_c   <= rom_data;
                    end
                    default: rsp_valid <= '0;
                endcase
            end
        end
    end

    assign v.rvalid = rsp_valid[0];
    assign b.rvalid = rsp_valid[1];
    assign c.rvalid = rsp_valid[2];
    assign v.rdata  = rdata_v;
    assign b.rdata  = rdata_b;
    assign c.rdata  = rdata_c;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Directed and random stimulus for map_access_arbiter, checked against a rule-level
// model: a priority decision per cycle plus a queue of responses due at fixed times.
module tb_map_access_arbiter;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 2;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 8;

    localparam int IDLE   = 0;
    localparam int CONT   = 1;
    localparam int SINGLE = 2;
    localparam int RAND   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              rom_en;
    logic              starve_evt;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    map_arb_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) v_if ();
    map_arb_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();
    map_arb_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c_if ();

    map_access_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .v          (v_if),
        .b          (b_if),
        .c          (c_if),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .starve_evt (starve_evt)
    );

    always #5 clk = ~clk;

    // ROM: data for an address presented at cycle N is visible at cycle N+RD_LAT.
    logic [DATA_W-1:0] mem [1<<ADDR_W];
    logic [ADDR_W-1:0] rom_pipe [RD_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = mem[rom_pipe[RD_LAT-1]];

    typedef struct {
        int                own;
        logic [ADDR_W-1:0] addr;
        int                due;
    } rsp_t;

    rsp_t              q[$];
    int                cyc = 0;
    int                n_assert = 0;
    int                n_fail = 0;
    int                mode [3];
    logic              r_req [3];
    logic [ADDR_W-1:0] r_addr [3];
    int                cnt [3];
    bit                rr_c;
    logic [DATA_W-1:0] exp_rd [3];
    bit                exp_rv [3];
    int                last_win = -1;
    int                obs_win;
    int                obs_cyc;
    bit                obs_starve;
    bit                obs_rv [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        v_if.req = r_req[0]; v_if.addr = r_addr[0];
        b_if.req = r_req[1]; b_if.addr = r_addr[1];
        c_if.req = r_req[2]; c_if.addr = r_addr[2];
    endtask

    // Requesters follow the hold-until-grant rule; behaviour chosen per requester by mode.
    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            bit g = (last_win == i);
            case (mode[i])
                CONT: begin
                    if (g || !r_req[i]) r_addr[i] = ADDR_W'($urandom);
                    r_req[i] = 1'b1;
                end
                SINGLE: begin
                    if (g) begin
                        r_req[i] = 1'b0;
                        mode[i]  = IDLE;
                    end
                end
                RAND: begin
                    if (g || !r_req[i]) begin
                        r_req[i]  = ($urandom_range(0, 3) != 0);
                        r_addr[i] = ADDR_W'($urandom);
                    end else if ($urandom_range(0, 15) == 0) begin
                        r_req[i] = 1'b0;
                    end
                end
                default: r_req[i] = 1'b0;
            endcase
        end
        apply();
    endtask

    // Winner according to the priority rules: urgent B/C, then V, then B/C by round-robin.
    task automatic arbitrate(output int win, output bit urg);
        bit ub = r_req[1] && (cnt[1] == STARVE_MAX);
        bit uc = r_req[2] && (cnt[2] == STARVE_MAX);
        win = -1;
        urg = 1'b0;
        if (ub || uc) begin
            urg = 1'b1;
            if (ub && uc) win = rr_c ? 2 : 1;
            else          win = ub ? 1 : 2;
        end else if (r_req[0]) win = 0;
        else if (r_req[1] && r_req[2]) win = rr_c ? 2 : 1;
        else if (r_req[1]) win = 1;
        else if (r_req[2]) win = 2;
    endtask

    task automatic step();
        int   win;
        bit   urg;
        rsp_t e;
        int   wi;
        @(negedge clk);
        obs_cyc = cyc;
        if (!reset) begin
            q.delete();
            rr_c = 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt[i]    = 0;
                exp_rd[i] = '0;
            end
        end
        for (int i = 0; i < 3; i++) exp_rv[i] = 1'b0;
        while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            exp_rv[e.own] = 1'b1;
            exp_rd[e.own] = mem[e.addr];
        end
        win = -1;
        urg = 1'b0;
        if (reset) arbitrate(win, urg);
        wi = (win < 0) ? 0 : win;

        obs_win    = v_if.gnt ? 0 : b_if.gnt ? 1 : c_if.gnt ? 2 : -1;
        obs_starve = starve_evt;
        obs_rv[0]  = v_if.rvalid;
        obs_rv[1]  = b_if.rvalid;
        obs_rv[2]  = c_if.rvalid;

        check($sformatf("c%0d v_gnt", cyc), v_if.gnt, 32'(win == 0));
        check($sformatf("c%0d b_gnt", cyc), b_if.gnt, 32'(win == 1));
        check($sformatf("c%0d c_gnt", cyc), c_if.gnt, 32'(win == 2));
        check($sformatf("c%0d rom_en", cyc), rom_en, 32'(win >= 0));
        check($sformatf("c%0d rom_addr", cyc), rom_addr, (win >= 0) ? 32'(r_addr[wi]) : 32'd0);
        check($sformatf("c%0d starve_evt", cyc), starve_evt, 32'(urg && r_req[0]));
        check($sformatf("c%0d v_rvalid", cyc), v_if.rvalid, 32'(exp_rv[0]));
        check($sformatf("c%0d b_rvalid", cyc), b_if.rvalid, 32'(exp_rv[1]));
        check($sformatf("c%0d c_rvalid", cyc), c_if.rvalid, 32'(exp_rv[2]));
        check($sformatf("c%0d v_rdata", cyc), v_if.rdata, 32'(exp_rd[0]));
        check($sformatf("c%0d b_rdata", cyc), b_if.rdata, 32'(exp_rd[1]));
        check($sformatf("c%0d c_rdata", cyc), c_if.rdata, 32'(exp_rd[2]));

        if (reset) begin
            for (int i = 1; i < 3; i++) begin
                if (!r_req[i] || win == i) cnt[i] = 0;
                else if (cnt[i] < STARVE_MAX) cnt[i]++;
            end
            if (win == 1)      rr_c = 1'b1;
            else if (win == 2) rr_c = 1'b0;
            if (win >= 0) q.push_back('{own: win, addr: r_addr[win], due: cyc + RD_LAT + 1});
        end
        last_win = win;
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic all_idle(input int n);
        for (int i = 0; i < 3; i++) begin
            mode[i]  = IDLE;
            r_req[i] = 1'b0;
        end
        apply();
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int  gcyc;
        int  raise;
        bit  found;
        bit  gstarve;
        int  rv_seen;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
        mem[14'h0105] = 2'b10;

        // Reset held with every requester asking: nothing may be granted or returned.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode[i]   = CONT;
            r_req[i]  = 1'b1;
            r_addr[i] = ADDR_W'($urandom);
        end
        apply();
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        step();
        check("post_reset_v_gnt", 32'(obs_win), 32'd0);

        // Round-robin between B and C with V idle, starting at B.
        mode[0]  = IDLE;
        r_req[0] = 1'b0;
        apply();
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("rr_order_%0d", k), 32'(obs_win), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        all_idle(6);

        // Single C read of a known location.
        mode[2]   = SINGLE;
        r_req[2]  = 1'b1;
        r_addr[2] = 14'h0105;
        apply();
        gcyc    = -1;
        rv_seen = -1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_win == 2 && gcyc < 0) gcyc = obs_cyc;
            if (obs_rv[2] && rv_seen < 0) rv_seen = obs_cyc;
        end
        check("single_c_latency", 32'(rv_seen - gcyc), 32'(RD_LAT + 1));
        check("single_c_rdata", c_if.rdata, 32'h2);
        all_idle(2);

        // Starvation: V streams, B must pre-empt after STARVE_MAX unserved cycles.
        mode[0] = CONT;
        for (int k = 0; k < 10; k++) step();
        mode[1]   = SINGLE;
        r_req[1]  = 1'b1;
        r_addr[1] = ADDR_W'($urandom);
        apply();
        raise   = cyc;
        found   = 1'b0;
        gcyc    = 0;
        gstarve = 1'b0;
        for (int k = 0; k < 3 * STARVE_MAX && !found; k++) begin
            step();
            if (obs_win == 1) begin
                found   = 1'b1;
                gcyc    = obs_cyc;
                gstarve = obs_starve;
            end
        end
        check("starve_b_granted", 32'(found), 32'd1);
        check("starve_b_latency", 32'(gcyc - raise), 32'(STARVE_MAX));
        check("starve_evt_at_grant", 32'(gstarve), 32'd1);
        step();
        check("starve_v_regrant", 32'(obs_win), 32'd0);
        all_idle(6);

        // Both urgent with the round-robin pointing at C: C, then B, then V.
        mode[1]  = SINGLE;
        r_req[1] = 1'b1;
        apply();
        for (int k = 0; k < 4; k++) step();
        mode[0] = CONT;
        r_req[0] = 1'b1;
        apply();
        step();
        mode[1]   = SINGLE;
        mode[2]   = SINGLE;
        r_req[1]  = 1'b1;
        r_req[2]  = 1'b1;
        r_addr[1] = ADDR_W'($urandom);
        r_addr[2] = ADDR_W'($urandom);
        apply();
        raise = cyc;
        found = 1'b0;
        gcyc  = 0;
        for (int k = 0; k < 3 * STARVE_MAX && !found; k++) begin
            step();
            if (obs_win == 1 || obs_win == 2) begin
                found = 1'b1;
                gcyc  = obs_cyc;
                check("both_urgent_first_c", 32'(obs_win), 32'd2);
            end
        end
        check("both_urgent_granted", 32'(found), 32'd1);
        check("both_urgent_latency", 32'(gcyc - raise), 32'(STARVE_MAX));
        step();
        check("both_urgent_then_b", 32'(obs_win), 32'd1);
        check("both_urgent_b_starve", 32'(obs_starve), 32'd1);
        step();
        check("both_urgent_then_v", 32'(obs_win), 32'd0);
        all_idle(6);

        // Reset while a V read is in flight: its response must never appear.
        mode[0]   = SINGLE;
        r_req[0]  = 1'b1;
        r_addr[0] = ADDR_W'($urandom);
        apply();
        step();
        check("flight_v_granted", 32'(obs_win), 32'd0);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        rv_seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_rv[0]) rv_seen++;
        end
        check("flight_no_v_rvalid", 32'(rv_seen), 32'd0);
        check("flight_v_rdata", v_if.rdata, 32'd0);

        // Random traffic from all three requesters.
        for (int i = 0; i < 3; i++) mode[i] = RAND;
        for (int k = 0; k < 600; k++) step();
        all_idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
